// File: rtl/updown_checker.sv
// Checks that a sampled up/down counter follows the triangle sequence 0..MAX..0.
// Reports mismatches and completed periods, each with a running count.
module updown_checker #(
    parameter int W   = 3,
    parameter int MAX = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_cnt,
    output logic         locked,
    output logic         dir,
    output logic         err,
    output logic [7:0]   err_cnt,
    output logic         period_done,
    output logic [15:0]  period_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [W-1:0] MAXV = W'(MAX);

    state_t       state, state_nxt;
    logic [W-1:0] prev, prev_nxt;
    logic [W-1:0] prev_inc, prev_dec;
    logic         err_nxt, pd_nxt, mismatch;
    logic [7:0]   err_cnt_nxt;
    logic [15:0]  period_cnt_nxt;

    assign prev_inc = prev + W'(1);
    assign prev_dec = prev - W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev        <= '0;
            locked      <= 1'b0;
            dir         <= 1'b1;
            err         <= 1'b0;
            err_cnt     <= '0;
            period_done <= 1'b0;
            period_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            locked      <= (state_nxt != IDLE);
            dir         <= (state_nxt != DOWN);
            err         <= err_nxt;
            err_cnt     <= err_cnt_nxt;
            period_done <= pd_nxt;
            period_cnt  <= period_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        err_nxt        = 1'b0;
        pd_nxt         = 1'b0;
        err_cnt_nxt    = err_cnt;
        period_cnt_nxt = period_cnt;
        mismatch       = 1'b0;

        if (clr) begin
            state_nxt      = IDLE;
            prev_nxt       = '0;
            err_cnt_nxt    = '0;
            period_cnt_nxt = '0;
        end else if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if (in_cnt == '0) begin
                        state_nxt = UP;
                        prev_nxt  = '0;
                    end
                end
                UP: begin
                    if (in_cnt == prev_inc) begin
                        prev_nxt = in_cnt;
                        if (in_cnt == MAXV) state_nxt = DOWN;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                DOWN: begin
                    if (in_cnt == prev_dec) begin
                        prev_nxt = in_cnt;
                        if (in_cnt == '0) begin
                            state_nxt      = UP;
                            pd_nxt         = 1'b1;
                            period_cnt_nxt = period_cnt + 16'd1;
                        end
                    end else begin
                        mismatch = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // The mismatching sample is consumed here; relock needs a fresh 0.
            if (mismatch) begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
                if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_updown_checker.sv
// Self-checking bench for updown_checker: a position-based triangle model feeds
// a scoreboard queue that is compared against the DUT one cycle after each sample.
module tb_updown_checker;

    localparam int W   = 3;
    localparam int MAX = 7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic [W-1:0] in_cnt;
    logic         locked, dir, err, period_done;
    logic [7:0]   err_cnt;
    logic [15:0]  period_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        locked;
        logic        dir;
        logic        err;
        logic [7:0]  ec;
        logic        pd;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    // Model: position within the 2*MAX-long period rather than state/prev.
    logic        m_locked;
    int          m_pos;
    logic [7:0]  m_ec;
    logic [15:0] m_pc;

    updown_checker #(.W(W), .MAX(MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_cnt      (in_cnt),
        .locked      (locked),
        .dir         (dir),
        .err         (err),
        .err_cnt     (err_cnt),
        .period_done (period_done),
        .period_cnt  (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tri_val(input int p);
        return (p <= MAX) ? p : 2 * MAX - p;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_ec     = '0;
        m_pc     = '0;
    endtask

    task automatic model_step(input logic c, input logic v, input logic [W-1:0] x);
        exp_t e;
        int   nxt;
        e.err = 1'b0;
        e.pd  = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (!m_locked) begin
                if (x == 0) begin
                    m_locked = 1'b1;
                    m_pos    = 0;
                end
            end else begin
                nxt = (m_pos + 1) % (2 * MAX);
                if (int'(x) == tri_val(nxt)) begin
                    m_pos = nxt;
                    if (nxt == 0) begin
                        e.pd = 1'b1;
                        m_pc = m_pc + 16'd1;
                    end
                end else begin
                    e.err    = 1'b1;
                    m_locked = 1'b0;
                    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                end
            end
        end
        e.locked = m_locked;
        e.dir    = m_locked ? (m_pos < MAX) : 1'b1;
        e.ec     = m_ec;
        e.pc     = m_pc;
        sb.push_back(e);
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic cyc(input logic c, input logic v, input logic [W-1:0] x);
        exp_t e;
        model_step(c, v, x);
        clr      = c;
        in_valid = v;
        in_cnt   = x;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("locked",      locked,      e.locked);
            check("dir",         dir,         e.dir);
            check("err",         err,         e.err);
            check("err_cnt",     err_cnt,     e.ec);
            check("period_done", period_done, e.pd);
            check("period_cnt",  period_cnt,  e.pc);
            check("no_err_and_pd", err & period_done, 1'b0);
        end
    endtask

    task automatic samp(input int x);
        cyc(1'b0, 1'b1, W'(x));
    endtask

    // Full 0..MAX..0 period; optionally interleave idle cycles holding in_cnt.
    task automatic period(input bit toggle);
        for (int i = 0; i < 2 * MAX + 1; i++) begin
            samp(tri_val(i % (2 * MAX)));
            if (toggle) cyc(1'b0, 1'b0, W'(tri_val(i % (2 * MAX))));
        end
    endtask

    task automatic do_clr();
        cyc(1'b1, 1'b0, '0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_dir"},    dir,    1'b1);
        check({tag, "_err"},    err,    1'b0);
        check({tag, "_ec"},     err_cnt, 8'd0);
        check({tag, "_pd"},     period_done, 1'b0);
        check({tag, "_pc"},     period_cnt, 16'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_cnt   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean stream with leading junk that must be ignored.
        samp(3);
        samp(5);
        check("junk_ignored_locked", locked, 1'b0);
        period(1'b0);
        check("clean_pc", period_cnt, 16'd1);
        check("clean_ec", err_cnt, 8'd0);
        check("clean_locked", locked, 1'b1);
        do_clr();

        // Skip in the UP ramp, then relock.
        samp(0); samp(1); samp(2); samp(4);
        check("skip_err", err, 1'b1);
        check("skip_ec", err_cnt, 8'd1);
        check("skip_locked", locked, 1'b0);
        samp(0); samp(1);
        check("relock_locked", locked, 1'b1);
        check("relock_err", err, 1'b0);
        check("relock_ec", err_cnt, 8'd1);
        do_clr();

        // Repeated MAX is a mismatch.
        for (int i = 0; i <= MAX; i++) samp(i);
        check("top_dir", dir, 1'b0);
        samp(MAX);
        check("repeat_err", err, 1'b1);
        check("repeat_ec", err_cnt, 8'd1);
        check("repeat_locked", locked, 1'b0);
        check("repeat_pc", period_cnt, 16'd0);
        do_clr();

        // Gapped valid, held data during gaps.
        samp(3); cyc(1'b0, 1'b0, W'(3));
        samp(5); cyc(1'b0, 1'b0, W'(5));
        period(1'b1);
        check("gap_pc", period_cnt, 16'd1);
        check("gap_ec", err_cnt, 8'd0);
        do_clr();

        // 300 mismatches via repeated zeros, then clr wins over a valid 0.
        for (int i = 0; i < 300; i++) begin
            samp(0);
            samp(0);
        end
        check("sat_ec", err_cnt, 8'd255);
        cyc(1'b1, 1'b1, '0);
        check("clr_ec", err_cnt, 8'd0);
        check("clr_pc", period_cnt, 16'd0);
        check("clr_locked", locked, 1'b0);

        // Asynchronous reset while descending at 4.
        for (int i = 0; i <= MAX; i++) samp(i);
        for (int i = MAX - 1; i >= 4; i--) samp(i);
        check("mid_down_dir", dir, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("held");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        period(1'b0);
        check("post_reset_pc", period_cnt, 16'd1);
        check("post_reset_ec", err_cnt, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
